// File: rtl/lr35902_vram_dma.sv
// rtl/lr35902_vram_dma.sv - VRAM DMA engine copying blocks into the 8 KiB VRAM window
module lr35902_vram_dma #(
    parameter int BLOCK_BYTES = 16,
    parameter int BYTE_CYCLES = 2,
    parameter int LEN_WIDTH   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  reg_adr,
    input  logic [7:0]  reg_din,
    input  logic        reg_write,
    output logic [7:0]  reg_dout,
    input  logic        hblank,
    output logic [15:0] adr_src,
    output logic [12:0] adr_dst,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        read,
    output logic        write,
    output logic        active
);

    localparam int SUB_W  = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
    localparam int BCNT_W = $clog2(BLOCK_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_COPY, S_HWAIT} state_t;

    state_t               state;
    logic [7:0]           sh_src_hi;
    logic [3:0]           sh_src_lo;
    logic [4:0]           sh_dst_hi;
    logic [3:0]           sh_dst_lo;
    logic [15:0]          wsrc;
    logic [12:0]          wdst;
    logic [LEN_WIDTH-1:0] rem_m1;
    logic [LEN_WIDTH-1:0] reload_val;
    logic                 hmode;
    logic                 armed;
    logic                 cancelled;
    logic                 cancel_pend;
    logic                 reload_pend;
    logic [SUB_W-1:0]     sub;
    logic [BCNT_W-1:0]    bcnt;
    logic                 strobe;

    logic ctl_wr, start, hbusy, hw_cancel, hw_reload, blk_go;
    logic byte_end, block_last, end_cancel, end_reload;
    logic [LEN_WIDTH-1:0] end_val;

    assign ctl_wr     = reg_write && (reg_adr == 3'd4);
    assign start      = ctl_wr && (state == S_IDLE);
    assign hbusy      = hmode && (state == S_COPY || state == S_HWAIT);
    assign hw_cancel  = ctl_wr && hbusy && !reg_din[7];
    assign hw_reload  = ctl_wr && hbusy && reg_din[7];
    assign blk_go     = (state == S_HWAIT) && hblank && armed && !hw_cancel;
    assign byte_end   = (sub == SUB_W'(BYTE_CYCLES - 1));
    assign block_last = (bcnt == BCNT_W'(BLOCK_BYTES - 1));
    // A control write landing on the block-end edge overrides any earlier pending request.
    assign end_cancel = hw_cancel || (cancel_pend && !hw_reload);
    assign end_reload = hw_reload || (reload_pend && !hw_cancel);
    assign end_val    = hw_reload ? reg_din[LEN_WIDTH-1:0] : reload_val;

    assign adr_src = wsrc;
    assign adr_dst = wdst;
    assign dout    = din;
    assign read    = strobe;
    assign write   = strobe;

    always_comb begin
        reg_dout = 8'hFF;
        if (state != S_IDLE || cancelled) begin
            reg_dout[LEN_WIDTH-1:0] = rem_m1;
            reg_dout[7]             = (state == S_IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            sh_src_hi   <= '0;
            sh_src_lo   <= '0;
            sh_dst_hi   <= '0;
            sh_dst_lo   <= '0;
            wsrc        <= '0;
            wdst        <= '0;
            rem_m1      <= '0;
            reload_val  <= '0;
            hmode       <= 1'b0;
            armed       <= 1'b0;
            cancelled   <= 1'b0;
            cancel_pend <= 1'b0;
            reload_pend <= 1'b0;
            sub         <= '0;
            bcnt        <= '0;
            strobe      <= 1'b0;
            active      <= 1'b0;
        end else begin
            strobe <= 1'b0;
            if (reg_write) begin
                case (reg_adr)
                    3'd0:    sh_src_hi <= reg_din;
                    3'd1:    sh_src_lo <= reg_din[7:4];
                    3'd2:    sh_dst_hi <= reg_din[4:0];
                    3'd3:    sh_dst_lo <= reg_din[7:4];
                    default: ;
                endcase
            end

            if (start && reg_din[7])
                armed <= 1'b1;
            else if (blk_go)
                armed <= 1'b0;
            else if (!hblank)
                armed <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        hmode       <= reg_din[7];
                        rem_m1      <= reg_din[LEN_WIDTH-1:0];
                        wsrc        <= {sh_src_hi, sh_src_lo, 4'b0};
                        wdst        <= {sh_dst_hi, sh_dst_lo, 4'b0};
                        cancelled   <= 1'b0;
                        cancel_pend <= 1'b0;
                        reload_pend <= 1'b0;
                        sub         <= '0;
                        bcnt        <= '0;
                        if (reg_din[7]) begin
                            state <= S_HWAIT;
                        end else begin
                            state  <= S_SETUP;
                            active <= 1'b1;
                        end
                    end
                end
                S_SETUP: begin
                    state  <= S_COPY;
                    strobe <= 1'b1;
                end
                S_COPY: begin
                    if (hw_cancel) begin
                        cancel_pend <= 1'b1;
                        reload_pend <= 1'b0;
                    end else if (hw_reload) begin
                        reload_pend <= 1'b1;
                        cancel_pend <= 1'b0;
                        reload_val  <= reg_din[LEN_WIDTH-1:0];
                    end
                    if (!byte_end) begin
                        sub <= sub + 1'b1;
                    end else begin
                        sub  <= '0;
                        wsrc <= wsrc + 16'd1;
                        wdst <= wdst + 13'd1;
                        bcnt <= bcnt + 1'b1;
                        if (!block_last) begin
                            strobe <= 1'b1;
                        end else begin
                            cancel_pend <= 1'b0;
                            reload_pend <= 1'b0;
                            if (end_reload) begin
                                rem_m1 <= end_val;
                                state  <= S_HWAIT;
                                active <= 1'b0;
                            end else if (rem_m1 == '0) begin
                                state  <= S_IDLE;
                                active <= 1'b0;
                            end else begin
                                rem_m1 <= rem_m1 - 1'b1;
                                if (end_cancel) begin
                                    state     <= S_IDLE;
                                    active    <= 1'b0;
                                    cancelled <= 1'b1;
                                end else if (hmode) begin
                                    state  <= S_HWAIT;
                                    active <= 1'b0;
                                end else begin
                                    strobe <= 1'b1;
                                end
                            end
                        end
                    end
                end
                S_HWAIT: begin
                    if (hw_cancel) begin
                        state     <= S_IDLE;
                        cancelled <= 1'b1;
                    end else begin
                        if (hw_reload)
                            rem_m1 <= reg_din[LEN_WIDTH-1:0];
                        if (blk_go) begin
                            state  <= S_COPY;
                            active <= 1'b1;
                            strobe <= 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lr35902_vram_dma.sv
// tb/tb_lr35902_vram_dma.sv - scoreboard bench for lr35902_vram_dma
module tb_lr35902_vram_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  reg_adr = '0;
    logic [7:0]  reg_din = '0;
    logic        reg_write = 1'b0;
    logic [7:0]  reg_dout;
    logic        hblank = 1'b0;
    logic [15:0] adr_src;
    logic [12:0] adr_dst;
    logic [7:0]  din = '0;
    logic [7:0]  dout;
    logic        read, write, active;

    lr35902_vram_dma #(.BLOCK_BYTES(16), .BYTE_CYCLES(2), .LEN_WIDTH(7)) dut (
        .clk(clk), .reset(reset), .reg_adr(reg_adr), .reg_din(reg_din),
        .reg_write(reg_write), .reg_dout(reg_dout), .hblank(hblank),
        .adr_src(adr_src), .adr_dst(adr_dst), .din(din), .dout(dout),
        .read(read), .write(write), .active(active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          t;
        logic [15:0] src;
        logic [12:0] dst;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   act_cnt = 0;
    int   t;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (active) act_cnt++;
        if (read || write) begin
            check("rw_pair", write, read);
            check("dout", dout, din);
            if (sb.size() == 0) begin
                check("extra_strobe", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("strobe_cycle", cyc, e.t);
                check("adr_src", adr_src, e.src);
                check("adr_dst", adr_dst, e.dst);
            end
        end
        din = 8'($urandom);
    end

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d, output int ts);
        @(negedge clk);
        reg_adr   = a;
        reg_din   = d;
        reg_write = 1'b1;
        ts        = cyc + 1;
        @(negedge clk);
        reg_write = 1'b0;
    endtask

    task automatic push_run(input int t0, input logic [15:0] s0, input logic [12:0] d0, input int n);
        exp_t x;
        for (int k = 0; k < n; k++) begin
            x.t   = t0 + k * 2;
            x.src = s0 + 16'(k);
            x.dst = d0 + 13'(k);
            sb.push_back(x);
        end
    endtask

    task automatic hpulse(input int hold, input bit expect_blk, input logic [15:0] s0, input logic [12:0] d0);
        @(negedge clk);
        hblank = 1'b1;
        if (expect_blk) push_run(cyc + 1, s0, d0, 16);
        repeat (hold) @(negedge clk);
        hblank = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] hb_exp [3];
        hb_exp[0] = 8'h01; hb_exp[1] = 8'h00; hb_exp[2] = 8'hFF;

        repeat (3) @(negedge clk);
        check("rst_active", active, 1'b0);
        check("rst_read", read, 1'b0);
        check("rst_write", write, 1'b0);
        check("rst_dout", reg_dout, 8'hFF);
        check("rst_src", adr_src, 16'h0000);
        check("rst_dst", adr_dst, 13'h0000);
        reset = 1'b0;

        // general mode, two blocks; ignored low/high register bits
        reg_wr(0, 8'hC0, t); reg_wr(1, 8'h0F, t); reg_wr(2, 8'hE0, t); reg_wr(3, 8'h0F, t);
        act_cnt = 0;
        reg_wr(4, 8'h01, t);
        push_run(t + 1, 16'hC000, 13'h0000, 32);
        check("gen_dout_busy", reg_dout, 8'h01);
        check("gen_active", active, 1'b1);
        repeat (10) @(negedge clk);
        reg_wr(5, 8'h00, t);
        reg_wr(4, 8'h00, t);
        repeat (70) @(negedge clk);
        check("gen_act_span", act_cnt, 65);
        check("gen_dout_done", reg_dout, 8'hFF);
        check("gen_drain", sb.size(), 0);

        // hblank mode, three pulses
        reg_wr(0, 8'h12, t); reg_wr(1, 8'h30, t); reg_wr(2, 8'h05, t); reg_wr(3, 8'h60, t);
        reg_wr(4, 8'h82, t);
        check("hb_dout_start", reg_dout, 8'h02);
        check("hb_idle_active", active, 1'b0);
        for (int p = 0; p < 3; p++) begin
            act_cnt = 0;
            hpulse(5, 1'b1, 16'h1230 + 16'(p * 16), 13'h0560 + 13'(p * 16));
            repeat (40) @(negedge clk);
            check("hb_act_span", act_cnt, 32);
            check("hb_gap_active", active, 1'b0);
            check("hb_dout", reg_dout, hb_exp[p]);
        end
        check("hb_drain", sb.size(), 0);

        // start while hblank is high; holding it high runs only one block
        @(negedge clk);
        hblank = 1'b1;
        reg_wr(4, 8'h81, t);
        push_run(t + 1, 16'h1230, 13'h0560, 16);
        repeat (60) @(negedge clk);
        check("hold_active", active, 1'b0);
        check("hold_dout", reg_dout, 8'h00);
        check("hold_drain", sb.size(), 0);
        @(negedge clk);
        hblank = 1'b0;
        hpulse(40, 1'b1, 16'h1240, 13'h0570);
        repeat (10) @(negedge clk);
        check("hold_done", reg_dout, 8'hFF);
        check("hold_drain2", sb.size(), 0);

        // cancel while waiting for hblank
        reg_wr(4, 8'h83, t);
        check("cw_start", reg_dout, 8'h03);
        hpulse(5, 1'b1, 16'h1230, 13'h0560);
        repeat (40) @(negedge clk);
        check("cw_wait", reg_dout, 8'h02);
        reg_wr(4, 8'h00, t);
        check("cw_cancel", reg_dout, 8'h82);
        check("cw_active", active, 1'b0);
        hpulse(5, 1'b0, 16'h0000, 13'h0000);
        repeat (40) @(negedge clk);
        check("cw_stays", reg_dout, 8'h82);

        // cancel mid-block: the block completes first
        reg_wr(4, 8'h83, t);
        check("cm_start", reg_dout, 8'h03);
        hpulse(5, 1'b1, 16'h1230, 13'h0560);
        repeat (40) @(negedge clk);
        hpulse(3, 1'b1, 16'h1240, 13'h0570);
        repeat (5) @(negedge clk);
        reg_wr(4, 8'h00, t);
        check("cm_busy", active, 1'b1);
        check("cm_dout_busy", reg_dout, 8'h02);
        repeat (40) @(negedge clk);
        check("cm_cancel", reg_dout, 8'h81);
        check("cm_active", active, 1'b0);
        hpulse(5, 1'b0, 16'h0000, 13'h0000);
        repeat (40) @(negedge clk);
        check("cm_stays", reg_dout, 8'h81);
        check("cm_drain", sb.size(), 0);

        // source and destination wrap
        reg_wr(0, 8'hFF, t); reg_wr(1, 8'hF0, t); reg_wr(2, 8'hFF, t); reg_wr(3, 8'hF0, t);
        reg_wr(4, 8'h01, t);
        push_run(t + 1, 16'hFFF0, 13'h1FF0, 32);
        repeat (80) @(negedge clk);
        check("wrap_done", reg_dout, 8'hFF);
        check("wrap_drain", sb.size(), 0);

        // reset in the middle of a copy
        reg_wr(4, 8'h00, t);
        push_run(t + 1, 16'hFFF0, 13'h1FF0, 5);
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mr_active", active, 1'b0);
        check("mr_read", read, 1'b0);
        check("mr_write", write, 1'b0);
        check("mr_dout", reg_dout, 8'hFF);
        check("mr_src", adr_src, 16'h0000);
        check("mr_dst", adr_dst, 13'h0000);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("mr_drain", sb.size(), 0);
        reg_wr(0, 8'h40, t); reg_wr(1, 8'h00, t); reg_wr(2, 8'h01, t); reg_wr(3, 8'h00, t);
        reg_wr(4, 8'h00, t);
        push_run(t + 1, 16'h4000, 13'h0100, 16);
        check("mr_restart", reg_dout, 8'h00);
        repeat (45) @(negedge clk);
        check("mr_done", reg_dout, 8'hFF);
        check("mr_drain2", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
